t_inv_trans: RTL and testbench

Inverse T-transform for the reconfigurable four-valued logic multiplier. It takes a (p+1)-digit quaternary T-word and the p-digit key operand b, checks the leading marker digit, and recovers the p-digit operand a one group of digits per cycle. Valid/ready handshakes on both sides let it sit between the T-domain datapath and the binary-coded result path.

---
 rtl/t_trans_pkg.sv | 16 +
 rtl/t_inv_digit.sv | 17 +
 rtl/t_inv_trans.sv | 132 +++++++++++++
 tb/tb_t_inv_trans.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/t_trans_pkg.sv
// Shared definitions for the T-transform blocks of the four-valued logic
// multiplier: quaternary digit width, the T-word marker digit and the
// sequencer state encoding.
package t_trans_pkg;

    localparam int DIGIT_W = 2;

    localparam logic [DIGIT_W-1:0] T_MARKER = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/t_inv_digit.sv
// Single-digit inverse T function: a = (t - b) mod 4.
// Ports:
//   t - T-word digit (the one above the marker-shifted position)
//   b - key operand digit
//   a - recovered operand digit
module t_inv_digit
    import t_trans_pkg::*;
(
    input  logic [DIGIT_W-1:0] t,
    input  logic [DIGIT_W-1:0] b,
    output logic [DIGIT_W-1:0] a
);

    // Two-bit subtraction wraps naturally, which is exactly mod 4.
    assign a = t - b;

endmodule

// File: rtl/t_inv_trans.sv
// Inverse T-transform. Accepts a (P+1)-digit quaternary T-word plus the
// P-digit key b, checks the marker digit and recovers operand a, DPC digits
// per cycle, least significant group first.
// Ports:
//   clk, rst_n           - clock, synchronous active-low reset
//   in_valid / in_ready  - input handshake for t_in and b_in
//   t_in                 - T-word, digit 0 is the marker
//   b_in                 - key operand
//   out_valid / out_ready- output handshake for a_out and err
//   a_out                - recovered operand (0 on a bad marker)
//   err                  - marker digit was not T_MARKER
module t_inv_trans
    import t_trans_pkg::*;
#(
    parameter int P   = 33,
    parameter int DPC = 3
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*P+1:0]   t_in,
    input  logic [2*P-1:0]   b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*P-1:0]   a_out,
    output logic             err
);

    localparam int N  = P / DPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int GW = DPC * DIGIT_W;

    state_t          state;
    logic [CW-1:0]   cnt;

    // Payload digits only; the marker is checked at accept time and dropped.
    logic [2*P-1:0]  t_reg;
    logic [2*P-1:0]  b_reg;
    logic [2*P-1:0]  a_reg;
    logic [2*P-1:0]  a_next;
    logic [GW-1:0]   grp;
    logic            accept;

    assign accept = (state == IDLE) && in_valid && in_ready;

    for (genvar j = 0; j < DPC; j++) begin : g_digit
        logic [DIGIT_W-1:0] t_d;
        logic [DIGIT_W-1:0] b_d;
        logic [DIGIT_W-1:0] a_d;

        assign t_d = t_reg[(int'(cnt) * DPC + j) * DIGIT_W +: DIGIT_W];
        assign b_d = b_reg[(int'(cnt) * DPC + j) * DIGIT_W +: DIGIT_W];

        t_inv_digit u_digit (
            .t (t_d),
            .b (b_d),
            .a (a_d)
        );

        assign grp[j*DIGIT_W +: DIGIT_W] = a_d;
    end

    // Merged view lets the final group reach a_out on the same edge it is
    // written, so a_out never exposes a partial word.
    always_comb begin
        a_next = a_reg;
        a_next[int'(cnt) * GW +: GW] = grp;
    end

    // Datapath registers: loaded on accept, filled group by group in RUN.
    always_ff @(posedge clk) begin
        if (accept) begin
            t_reg <= t_in[2*P+1:2];
            b_reg <= b_in;
            a_reg <= '0;
        end else if (state == RUN) begin
            a_reg <= a_next;
        end
    end

    // Sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            a_out     <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        cnt      <= '0;
                        if (t_in[DIGIT_W-1:0] == T_MARKER) begin
                            err   <= 1'b0;
                            state <= RUN;
                        end else begin
                            err       <= 1'b1;
                            a_out     <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) begin
                        a_out     <= a_next;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t_inv_trans.sv
// Self-checking bench for t_inv_trans: directed marker, wrap-around,
// backpressure and mid-run reset cases, then randomized words built with the
// forward digit function and compared against the original operand.
module tb_t_inv_trans;

    localparam int P  = 33;
    localparam int TW = 2 * P + 2;
    localparam int AW = 2 * P;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] t_in;
    logic [AW-1:0] b_in;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] a_out;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_hs   = 0;
    int n_exp  = 0;

    t_inv_trans #(.P(P), .DPC(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .t_in      (t_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_out     (a_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) n_hs <= n_hs + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Forward transform: t digit (i+1) = (a_i + b_i) mod 4, marker in digit 0.
    function automatic logic [TW-1:0] fwd(input logic [AW-1:0] a, input logic [AW-1:0] b);
        logic [TW-1:0] t;
        t[1:0] = 2'b01;
        for (int i = 0; i < P; i++) begin
            int s;
            s = (int'(a[2*i +: 2]) + int'(b[2*i +: 2])) % 4;
            t[2*i+2 +: 2] = 2'(s);
        end
        return t;
    endfunction

    function automatic logic [AW-1:0] rand_word();
        logic [AW-1:0] w;
        for (int i = 0; i < P; i++) w[2*i +: 2] = 2'($urandom_range(0, 3));
        return w;
    endfunction

    task automatic put_word(input logic [TW-1:0] t, input logic [AW-1:0] b, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        chk("in_ready_wait", in_ready, 1);
        t_in = t;
        b_in = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take_word();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_exp++;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_rise", in_ready, 1);
    endtask

    initial begin
        int lat;
        logic [AW-1:0] a_w, b_w;
        logic [TW-1:0] t_w;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        t_in = '0; b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1);

        // All a = 3, b = 2 gives every t payload digit = 1.
        put_word({34{2'b01}}, {33{2'b10}}, lat);
        chk("lat_good", lat, 12);
        chk("a_all3", a_out, {33{2'b11}});
        chk("err_good", err, 0);
        take_word();

        // Bad marker, then a good word must clear err.
        put_word({{33{2'b10}}, 2'b10}, {33{2'b01}}, lat);
        chk("lat_bad", lat, 1);
        chk("err_bad", err, 1);
        chk("a_bad", a_out, 0);
        take_word();
        a_w = rand_word(); b_w = rand_word();
        put_word(fwd(a_w, b_w), b_w, lat);
        chk("lat_after_bad", lat, 12);
        chk("err_after_bad", err, 0);
        chk("a_after_bad", a_out, a_w);
        take_word();

        // Wrap-around subtraction.
        put_word({{33{2'b00}}, 2'b01}, {33{2'b11}}, lat);
        chk("wrap_t0_b3", a_out, {33{2'b01}});
        take_word();
        put_word({{33{2'b11}}, 2'b01}, {33{2'b00}}, lat);
        chk("wrap_t3_b0", a_out, {33{2'b11}});
        take_word();

        // Backpressure, with a competing in_valid that must be ignored.
        a_w = rand_word(); b_w = rand_word();
        put_word(fwd(a_w, b_w), b_w, lat);
        t_in = fwd(b_w, a_w); b_in = a_w; in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_a", a_out, a_w);
            chk("bp_err", err, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        take_word();

        // Reset while RUN holds cnt = 5.
        a_w = rand_word(); b_w = rand_word();
        t_in = fwd(a_w, b_w); b_in = b_w; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_run_no_out", out_valid, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_a_out", a_out, 0);
        chk("mrst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_idle", in_ready, 1);
        repeat (15) begin
            @(posedge clk); #1;
            chk("mrst_discard", out_valid, 0);
        end
        a_w = rand_word(); b_w = rand_word();
        put_word(fwd(a_w, b_w), b_w, lat);
        chk("mrst_lat", lat, 12);
        chk("mrst_a", a_out, a_w);
        take_word();

        // Randomized words with random consumer stalls.
        for (int k = 0; k < 1000; k++) begin
            int stall;
            a_w = rand_word(); b_w = rand_word();
            t_w = fwd(a_w, b_w);
            put_word(t_w, b_w, lat);
            chk("rnd_lat", lat, 12);
            chk("rnd_a", a_out, a_w);
            chk("rnd_err", err, 0);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk("rnd_hold", a_out, a_w);
            end
            take_word();
        end

        chk("handshake_count", n_hs, n_exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
